sr_ff_bank: RTL

Parametrised bank of clocked SR flip-flops with WIDTH independent channels, a runtime-selectable policy for the S=R=1 case, and registered change-detect pulses. It also tracks S=R=1 conflicts with a sticky flag and a saturating counter. It serves as the general-purpose synchronous set/reset storage element for status and control bits, in place of unclocked latches.

---
 rtl/sr_pkg.sv | 33 +++
 rtl/sr_cell.sv | 40 ++++
 rtl/sr_ff_bank.sv | 68 ++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared constants and next-state helper for the clocked SR flip-flop bank.
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_SET_DOM = 2'b01;
  localparam logic [1:0] SR_RST_DOM = 2'b10;
  localparam logic [1:0] SR_TOGGLE  = 2'b11;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // Next value of one SR channel; mode only matters when s and r collide.
  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input logic [1:0] mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nq = 1'b1;
          SR_RST_DOM: nq = 1'b0;
          SR_TOGGLE:  nq = ~q;
          default:    nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One clocked SR channel: state register plus a registered change pulse.
module sr_cell
  import sr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       s,
  input  logic       r,
  input  logic [1:0] mode,
  output logic       q,
  output logic       changed
);

  logic q_q, q_d;
  logic chg_q, chg_d;

  always_comb begin
    q_d   = q_q;
    chg_d = 1'b0;
    if (en) begin
      q_d   = sr_next(s, r, q_q, mode);
      chg_d = q_d ^ q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

  assign q       = q_q;
  assign changed = chg_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with shared S=R=1 policy and conflict
// tracking (sticky flag plus saturating cycle counter).
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [1:0]       mode,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic             both_err,
  output logic [CNT_W-1:0] both_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             conflict;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .s       (s[i]),
      .r       (r[i]),
      .mode    (mode),
      .q       (q[i]),
      .changed (changed[i])
    );
  end

  assign conflict = en & (|(s & r));

  // Clear is applied first so a coincident conflict still registers.
  always_comb begin
    err_d = clr_err ? 1'b0 : err_q;
    cnt_d = clr_err ? '0 : cnt_q;
    if (conflict) begin
      err_d = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign qn       = ~q;
  assign both_err = err_q;
  assign both_cnt = cnt_q;

endmodule
